// File: rtl/alu_div_unit_pkg.sv
// Shared constants for the multi-cycle divider: FSM encoding, ALU opcode, divide-by-zero quotient.
package alu_div_unit_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Extends the 4-bit ALU_Operation space alongside the combinational ops.
    localparam logic [3:0] ALU_OP_DIV = 4'b0011;

    // Widest supported operand; narrower builds take the low bits.
    localparam int unsigned DIV_MAX_WIDTH = 64;
    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/alu_div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import alu_div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  msb_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_c_o,
    output logic                  qbit_c_o
);

    logic [DATA_WIDTH:0] shifted_c;
    logic [DATA_WIDTH:0] diff_c;

    // rem_i < divisor_i, so a non-negative difference always fits DATA_WIDTH bits.
    assign shifted_c = {rem_i, msb_i};
    assign diff_c    = shifted_c - {1'b0, divisor_i};
    assign qbit_c_o  = ~diff_c[DATA_WIDTH];
    assign rem_c_o   = qbit_c_o ? diff_c[DATA_WIDTH-1:0] : shifted_c[DATA_WIDTH-1:0];

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle restoring divider with start/done handshake, one quotient bit per clock.
// Define DIV_SIGNED_EN to honour Signed_Op (two's-complement); otherwise all divides are unsigned.
module alu_div_unit
    import alu_div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic                  Signed_Op,
    input  logic [DATA_WIDTH-1:0] Read_Data_1,
    input  logic [DATA_WIDTH-1:0] Read_Data_2,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Quotient,
    output logic [DATA_WIDTH-1:0] Remainder,
    output logic                  Div_By_Zero
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [ST_W-1:0]       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] remr_q, remr_d;
    logic                  dbz_q, dbz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] mag_a_c, mag_b_c;
    logic [DATA_WIDTH-1:0] step_rem_c;
    logic                  step_qbit_c;
    logic [DATA_WIDTH-1:0] q_raw_c, q_fin_c, r_fin_c;

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[DATA_WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_c_o   (step_rem_c),
        .qbit_c_o  (step_qbit_c)
    );

    // Quotient bits shift into the dividend register as its bits are consumed.
    assign q_raw_c = {dvd_q[DATA_WIDTH-2:0], step_qbit_c};

`ifdef DIV_SIGNED_EN
    logic sgn_a_c, sgn_b_c, accept_run_c;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    assign sgn_a_c      = Signed_Op & Read_Data_1[DATA_WIDTH-1];
    assign sgn_b_c      = Signed_Op & Read_Data_2[DATA_WIDTH-1];
    assign mag_a_c      = sgn_a_c ? -Read_Data_1 : Read_Data_1;
    assign mag_b_c      = sgn_b_c ? -Read_Data_2 : Read_Data_2;
    assign accept_run_c = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && Start
                          && (Read_Data_2 != '0);
    assign neg_quo_d    = accept_run_c ? (sgn_a_c ^ sgn_b_c) : neg_quo_q;
    assign neg_rem_d    = accept_run_c ? sgn_a_c : neg_rem_q;
    assign q_fin_c      = neg_quo_q ? -q_raw_c : q_raw_c;
    assign r_fin_c      = neg_rem_q ? -step_rem_c : step_rem_c;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = Signed_Op;
    assign mag_a_c          = Read_Data_1;
    assign mag_b_c          = Read_Data_2;
    assign q_fin_c          = q_raw_c;
    assign r_fin_c          = step_rem_c;
`endif

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        remr_d  = remr_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (Start) begin
                    if (Read_Data_2 == '0) begin
                        state_d = ST_DONE;
                        quo_d   = DIV_ZERO_QUOTIENT[DATA_WIDTH-1:0];
                        remr_d  = Read_Data_1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(DATA_WIDTH);
                        rem_d   = '0;
                        dvd_d   = mag_a_c;
                        dvs_d   = mag_b_c;
                    end
                end
            end
            ST_RUN: begin
                rem_d = step_rem_c;
                dvd_d = q_raw_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    quo_d   = q_fin_c;
                    remr_d  = r_fin_c;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            remr_q  <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            remr_q  <= remr_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Quotient    = quo_q;
    assign Remainder   = remr_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed self-checking bench for alu_div_unit at the default 32-bit width.
module tb_alu_div_unit;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic        Signed_Op;
    logic [31:0] Read_Data_1;
    logic [31:0] Read_Data_2;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Div_By_Zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_div_unit #(.DATA_WIDTH(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Start       (Start),
        .Signed_Op   (Signed_Op),
        .Read_Data_1 (Read_Data_1),
        .Read_Data_2 (Read_Data_2),
        .Busy        (Busy),
        .Done        (Done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_By_Zero (Div_By_Zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Assert Start for one cycle; returns 1 ns after the accepting edge (cycle t+1).
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        Start       = 1'b1;
        Signed_Op   = sgn;
        Read_Data_1 = a;
        Read_Data_2 = b;
        @(posedge CLK);
        #1;
        Start       = 1'b0;
        Read_Data_1 = 32'hDEAD_BEEF;
        Read_Data_2 = 32'h0;
    endtask

    // Walk from cycle t+1 to Done, optionally pulsing Start (9 / 3) at relative cycle inject.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] eq,
                             input logic [31:0] er, input logic edbz, input int inject);
        int  k      = 1;
        int  busy_n = 0;
        bit  seen   = 0;
        while (k <= 100 && !seen) begin
            if (inject != 0) begin
                Start = (k == inject);
                if (k == inject) begin
                    Read_Data_1 = 32'd9;
                    Read_Data_2 = 32'd3;
                end
            end
            if (Done) begin
                seen = 1;
            end else begin
                if (Busy) busy_n++;
                @(posedge CLK);
                #1;
                k++;
            end
        end
        Start = 1'b0;
        check({tag, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check({tag, "_busy_at_done"}, {31'd0, Busy}, 32'd0);
        check({tag, "_quotient"}, Quotient, eq);
        check({tag, "_remainder"}, Remainder, er);
        check({tag, "_dbz"}, {31'd0, Div_By_Zero}, {31'd0, edbz});
    endtask

    task automatic done_drops(input string tag);
        @(posedge CLK);
        #1;
        check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz);
        drive_start(a, b, sgn);
        wait_done(tag, edbz ? 1 : 33, eq, er, edbz, 0);
        done_drops(tag);
    endtask

    initial begin
        RST         = 1'b0;
        Start       = 1'b0;
        Signed_Op   = 1'b0;
        Read_Data_1 = '0;
        Read_Data_2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_quotient", Quotient, 32'd0);
        check("rst_remainder", Remainder, 32'd0);
        check("rst_dbz", {31'd0, Div_By_Zero}, 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        run_op("u6_7", 32'd6, 32'd7, 1'b0, 32'd0, 32'd6, 1'b0);
        run_op("u0_5", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
        run_op("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0);

        // Start pulsed mid-run is ignored; then a back-to-back start in the Done cycle.
        drive_start(32'd100, 32'd7, 1'b0);
        wait_done("ignored_start", 33, 32'd14, 32'd2, 1'b0, 6);
        drive_start(32'd9, 32'd3, 1'b0);
        wait_done("back_to_back", 33, 32'd3, 32'd0, 1'b0, 0);
        done_drops("back_to_back");

        run_op("dbz5", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);

        // Asynchronous reset at cycle t+10 of an operation.
        drive_start(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_done", {31'd0, Done}, 32'd0);
        check("midrst_quotient", Quotient, 32'd0);
        check("midrst_remainder", Remainder, 32'd0);
        check("midrst_dbz", {31'd0, Div_By_Zero}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        run_op("after_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);

`ifdef DIV_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_op("s_dbz", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        run_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
`else
        run_op("nosign_fffe_2", 32'hFFFF_FFFE, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0);
        run_op("nosign_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
